// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: walks (m, n, k) blocks, drives A/B read addresses
// and MAC strobes, then writes each finished block to SRAM C in order.
module gemm_tile_sequencer #(
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic                     mac_valid_o,
  output logic                     mac_clear_o,
  output logic                     mac_last_o,
  input  logic                     result_valid_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, WRITE, FINISH
  } state_t;

  localparam logic [SizeAddrWidth-1:0] SOne = 1;
  localparam logic [AddrWidth-1:0]     AOne = 1;

  state_t                   r_state;
  logic [SizeAddrWidth-1:0] r_msz, r_ksz, r_nsz;
  logic [SizeAddrWidth-1:0] r_m, r_n, r_k;
  logic [AddrWidth-1:0]     r_a_base, r_b_base;
  logic [AddrWidth-1:0]     r_a_addr, r_b_addr, r_c_addr;
  logic                     r_valid, r_clear, r_last;
  logic                     r_we, r_busy, r_done;

  logic                     w_k_last, w_n_last, w_m_last;
  logic                     w_any_zero;
  logic [AddrWidth-1:0]     w_kstep;

  assign w_k_last   = (r_k == r_ksz - SOne);
  assign w_n_last   = (r_n == r_nsz - SOne);
  assign w_m_last   = (r_m == r_msz - SOne);
  assign w_any_zero = (M_size_i == '0) | (K_size_i == '0) |
                      (N_size_i == '0);
  assign w_kstep    = AddrWidth'(r_ksz);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_msz    <= '0;
      r_ksz    <= '0;
      r_nsz    <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_c_addr <= '0;
      r_valid  <= 1'b0;
      r_clear  <= 1'b0;
      r_last   <= 1'b0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_clear <= 1'b0;
      r_last  <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_msz  <= M_size_i;
            r_ksz  <= K_size_i;
            r_nsz  <= N_size_i;
            r_busy <= 1'b1;
            if (w_any_zero) begin
              r_state <= FINISH;
            end else begin
              r_m      <= '0;
              r_n      <= '0;
              r_k      <= '0;
              r_a_base <= '0;
              r_b_base <= '0;
              r_a_addr <= '0;
              r_b_addr <= '0;
              r_c_addr <= '0;
              r_state  <= FETCH;
            end
          end
        end
        FETCH: begin
          // strobes lag the address by one cycle to match SRAM latency
          r_valid <= 1'b1;
          r_clear <= (r_k == '0);
          r_last  <= w_k_last;
          if (w_k_last) begin
            r_k     <= '0;
            r_state <= DRAIN;
          end else begin
            r_k      <= r_k + SOne;
            r_a_addr <= r_a_addr + AOne;
            r_b_addr <= r_b_addr + AOne;
          end
        end
        DRAIN: begin
          if (result_valid_i) begin
            r_we    <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_c_addr <= r_c_addr + AOne;
          if (w_n_last) begin
            r_n      <= '0;
            r_b_base <= '0;
            r_b_addr <= '0;
            if (w_m_last) begin
              r_state <= FINISH;
            end else begin
              r_m      <= r_m + SOne;
              r_a_base <= r_a_base + w_kstep;
              r_a_addr <= r_a_base + w_kstep;
              r_state  <= FETCH;
            end
          end else begin
            r_n      <= r_n + SOne;
            r_b_base <= r_b_base + w_kstep;
            r_b_addr <= r_b_base + w_kstep;
            r_a_addr <= r_a_base;
            r_state  <= FETCH;
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_a_addr_o = r_a_addr;
  assign sram_b_addr_o = r_b_addr;
  assign mac_valid_o   = r_valid;
  assign mac_clear_o   = r_clear;
  assign mac_last_o    = r_last;
  assign sram_c_addr_o = r_c_addr;
  assign sram_c_we_o   = r_we;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer: a reference model fills
// expected beat/write queues, a monitor pops them as the DUT emits.
module tb_gemm_tile_sequencer;

  localparam int AW = 12;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] msz = '0, ksz = '0, nsz = '0;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic          valid, clear, last, rv, we, busy, done;

  gemm_tile_sequencer #(.AddrWidth(AW), .SizeAddrWidth(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(msz), .K_size_i(ksz), .N_size_i(nsz),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr),
    .mac_valid_o(valid), .mac_clear_o(clear), .mac_last_o(last),
    .result_valid_i(rv),
    .sram_c_addr_o(c_addr), .sram_c_we_o(we),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    bit c;
    bit l;
  } beat_t;

  beat_t q_beat[$];
  int    q_wr[$];
  int    n_chk = 0, n_fail = 0;
  int    n_beat = 0, n_wr = 0, n_done = 0;
  int    mesh_dly = 1;
  bit    spur = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every (m,n) block in row-major order, k innermost.
  task automatic model(int M, int K, int N);
    beat_t e;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) begin
        for (int k = 0; k < K; k++) begin
          e.a = (m * K + k) % (1 << AW);
          e.b = (n * K + k) % (1 << AW);
          e.c = (k == 0);
          e.l = (k == K - 1);
          q_beat.push_back(e);
        end
        q_wr.push_back(m * N + n);
      end
  endtask

  // Mesh model: pulses result valid mesh_dly cycles after the last beat.
  initial begin
    int cnt;
    cnt = -1;
    rv = 1'b0;
    forever begin
      @(negedge clk);
      rv = 1'b0;
      if (rst) cnt = -1;
      else begin
        if (cnt > 0) cnt--;
        if (valid && last) cnt = mesh_dly;
        if (cnt == 0) begin
          rv = 1'b1;
          cnt = -1;
        end else if (spur && valid && !last && $urandom_range(0, 2) == 0)
          rv = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int    pa, pb;
    bit    in_drain;
    beat_t e;
    pa = 0;
    pb = 0;
    in_drain = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) in_drain = 1'b0;
      if (valid) begin
        n_beat++;
        if (q_beat.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = q_beat.pop_front();
          chk("a_addr", pa, e.a);
          chk("b_addr", pb, e.b);
          chk("clear", int'(clear), int'(e.c));
          chk("last", int'(last), int'(e.l));
        end
        if (last) in_drain = 1'b1;
      end
      if (in_drain && !rst) begin
        chk("a_hold", int'(a_addr), pa);
        chk("b_hold", int'(b_addr), pb);
      end
      if (we) begin
        n_wr++;
        in_drain = 1'b0;
        if (q_wr.size() == 0) chk("extra_write", 1, 0);
        else chk("c_addr", int'(c_addr), q_wr.pop_front());
      end
      if (done) n_done++;
      pa = int'(a_addr);
      pb = int'(b_addr);
    end
  end

  task automatic chk_zero(string nm);
    chk({nm, "_outs"},
        int'({a_addr, b_addr, c_addr, valid, clear, last, we, busy, done}),
        0);
  endtask

  task automatic run(int M, int K, int N, int d, bit sp, int restart_at);
    int  w0, b0, d0, cyc;
    bit  seen, zero;
    w0 = n_wr;
    b0 = n_beat;
    d0 = n_done;
    cyc = 0;
    seen = 1'b0;
    zero = (M == 0) || (K == 0) || (N == 0);
    if (!zero) model(M, K, N);
    mesh_dly = d;
    spur = sp;
    @(posedge clk);
    #1;
    msz = SW'(M);
    ksz = SW'(K);
    nsz = SW'(N);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_high", int'(busy), 1);
      if (cyc == restart_at) begin
        start = 1'b1;
        msz = 3;
        ksz = 2;
        nsz = 3;
      end else start = 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    spur = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    if (zero) chk("done_latency", cyc, 2);
    chk("busy_at_done", int'(busy), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("write_count", n_wr - w0, zero ? 0 : M * N);
    chk("beat_count", n_beat - b0, zero ? 0 : M * N * K);
    chk("done_count", n_done - d0, 1);
    chk("beats_left", q_beat.size(), 0);
    chk("writes_left", q_wr.size(), 0);
  endtask

  initial begin
    int b0, cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run(1, 1, 1, 1, 1'b0, 0);
    run(1, 16, 4, 2, 1'b0, 0);
    run(2, 3, 2, 5, 1'b0, 0);
    run(1, 3, 2, 0, 1'b0, 0);
    run(4, 0, 4, 1, 1'b0, 0);
    run(0, 5, 2, 1, 1'b0, 0);
    run(2, 3, 2, 2, 1'b0, 5);
    run(2, 5, 3, 1, 1'b1, 0);
    run(22, 200, 1, 1, 1'b0, 0);

    // abort in the drain of the second block
    model(2, 4, 2);
    mesh_dly = 30;
    b0 = n_beat;
    @(posedge clk);
    #1;
    msz = 2;
    ksz = 4;
    nsz = 2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (n_beat - b0 < 8 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) chk("abort_timeout", 0, 1);
    chk("abort_writes", q_wr.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    q_beat.delete();
    q_wr.delete();
    run(2, 4, 2, 1, 1'b0, 0);

    for (int i = 0; i < 12; i++)
      run($urandom_range(1, 3), $urandom_range(1, 6),
          $urandom_range(1, 3), $urandom_range(0, 4),
          1'($urandom_range(0, 1)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Control/address-generation stage that sits directly upstream of the MAC mesh inside the GEMM accelerator. It walks the output-block grid (m, n) and, for each output block, the K reduction blocks. For each step it drives block-packed SRAM A/B read addresses and operand-valid/clear/last strobes to the mesh. It then writes the finished output block to SRAM C at row-major block address m*N+n and signals completion.

Parameters:
AddrWidth, 12, SRAM word address width (DataDepth 4096)
SizeAddrWidth, 8, width of the M/K/N block-count inputs

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse; sampled only in IDLE
M_size_i  in  SizeAddrWidth  output row blocks (meshRow rows each)
K_size_i  in  SizeAddrWidth  reduction blocks (tileSize each)
N_size_i  in  SizeAddrWidth  output column blocks (meshCol cols each)
sram_a_addr_o  out  AddrWidth  A read address = m*K+k
sram_b_addr_o  out  AddrWidth  B read address = n*K+k
mac_valid_o  out  1  SRAM rdata this cycle is a valid operand pair
mac_clear_o  out  1  with mac_valid_o: first k, so the mesh overwrites its accumulators
mac_last_o  out  1  with mac_valid_o: last k of the current output block
result_valid_i  in  1  mesh pulse: accumulated block is on sram_c_wdata
sram_c_addr_o  out  AddrWidth  C write address = m*N+n
sram_c_we_o  out  1  C write enable, 1-cycle pulse
busy_o  out  1  high from accepted start until done
done_o  out  1  1-cycle completion pulse

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: state IDLE; all counters 0; every output 0. Reset mid-run aborts immediately and issues no further writes.
- States: IDLE, FETCH, DRAIN, WRITE, FINISH.
- IDLE:
  - On start_i, latch M/K/N and set busy_o=1.
  - If any size is 0, go to FINISH. No reads, no writes.
  - Otherwise set m=n=k=0 and go to FETCH.
  - start_i in any other state is ignored. Latched sizes do not change mid-run.
- FETCH:
  - Each cycle present sram_a_addr_o=m*K+k and sram_b_addr_o=n*K+k, then k++.
  - The step with k=K-1 moves to DRAIN, with k reset to 0.
  - Addresses come from incremental base registers (a_base += K per m, b_base += K per n). No multipliers.
  - All address sums truncate to AddrWidth.
- Operand strobes:
  - mac_valid_o/mac_clear_o/mac_last_o are the issue flags delayed by exactly one cycle, matching SRAM read latency.
  - clear=(k==0) and last=(k==K-1). When K=1, clear and last are both high on the same beat.
- DRAIN:
  - Addresses hold their last value. Wait for result_valid_i.
  - result_valid_i outside DRAIN is ignored.
  - result_valid_i arriving in the same cycle as the last mac_valid_o is accepted (DRAIN is entered that cycle).
  - On acceptance go to WRITE.
- WRITE (one cycle):
  - sram_c_we_o=1, sram_c_addr_o=m*N+n.
  - Advance n; on n wrap to 0, advance m. If m wraps, go to FINISH; otherwise go to FETCH.
- FINISH (one cycle): done_o=1, busy_o=0, then IDLE.
- Per output block: K fetch cycles, plus the DRAIN wait, plus 1 WRITE cycle.
- C writes are issued strictly in order 0,1,...,M*N-1. Exactly M*N writes and M*N*K valid beats per run.
- sram_c_addr_o, sram_c_we_o, done_o and the mac_* strobes are registered outputs.

Test Plan:
- M=1,K=1,N=1, mesh model pulses result_valid_i 1 cycle after last -> a/b addr 0; one beat with valid+clear+last on the same cycle; one write to C addr 0; done_o pulses once; busy_o low afterwards.
- M=1,K=16,N=4 -> A addr 0..15 repeated 4 times; B addr 0..15, 16..31, 32..47, 48..63; 64 valid beats; clear on beats 0,16,32,48; last on beats 15,31,47,63; C writes to 0,1,2,3 in order.
- M=2,K=3,N=2 with result_valid_i delayed 5 cycles -> A seq 0,1,2,0,1,2,3,4,5,3,4,5; B seq 0,1,2,3,4,5,0,1,2,3,4,5; addresses hold during DRAIN; C writes 0,1,2,3.
- K_size_i=0 (M=N=4) -> no mac_valid_o, no sram_c_we_o; done_o two cycles after start.
- start_i re-pulsed mid-run with different sizes -> ignored; original write count M*N is preserved.
- rst_i asserted during DRAIN of block 2 (M=N=2,K=4) -> next cycle all outputs 0 and state IDLE; a subsequent start runs cleanly from C addr 0.
- Spurious result_valid_i during FETCH -> no write; run completes with correct address sequence.
